// File: rtl/kb_event_queue_if.sv
// Keyboard event queue bus.
// Groups the key inputs from kb_driver, the CPU pop/clear strobes and the MMIO status/data word.
//   ascii     : current key code, 0 when no key is held
//   key_flags : {is_error, is_special, is_capital, is_ctrl, is_shift}
//   pop       : one-cycle strobe, removes the head entry
//   clr_ovf   : one-cycle strobe, clears the sticky overflow flag
//   q_data    : show-ahead status/data word
// master drives the inputs and reads q_data; slave is the queue itself.
interface kb_event_queue_if;
  logic [7:0]  ascii;
  logic [4:0]  key_flags;
  logic        pop;
  logic        clr_ovf;
  logic [31:0] q_data;

  modport master (
    output ascii,
    output key_flags,
    output pop,
    output clr_ovf,
    input  q_data
  );

  modport slave (
    input  ascii,
    input  key_flags,
    input  pop,
    input  clr_ovf,
    output q_data
  );
endinterface

// File: rtl/kb_event_queue.sv
// Keyboard event queue with typematic auto-repeat.
// A three-state FSM (idle, initial delay, repeat) turns the held key code into push events:
// one entry per new press, then repeat entries after REPEAT_DELAY cycles and every
// REPEAT_RATE cycles afterwards. Entries go into a DEPTH-deep FIFO read through q_data.
// Ports:
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset
//   kb_io  : queue bus (ascii, key_flags, pop, clr_ovf in; q_data out)
// q_data layout:
//   [7:0] head ascii, [11:8] head {special, capital, ctrl, shift}, [12] head-is-repeat,
//   [20:16] occupancy, [24] overflow, [31] non-empty, all other bits 0.
module kb_event_queue #(
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned REPEAT_DELAY = 25000000,
  parameter int unsigned REPEAT_RATE  = 5000000
) (
  input logic             clk,
  input logic             rst_n,
  kb_event_queue_if.slave kb_io
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [31:0]   DelayLast = 32'(REPEAT_DELAY - 1);
  localparam logic [31:0]   RateLast  = 32'(REPEAT_RATE - 1);
  localparam logic [CW-1:0] CntFull   = CW'(DEPTH);

  typedef enum logic [1:0] {
    StIdle,
    StDelay,
    StRepeat
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] timer_q, timer_d;
  logic [7:0]  code_q, code_d;

  logic        key_err, key_on, key_new;
  logic        push, push_rpt;
  logic [12:0] push_entry;

  assign key_err = kb_io.key_flags[4];
  assign key_on  = (kb_io.ascii != 8'h00);
  assign key_new = key_on && (kb_io.ascii != code_q);

  // ---------------------------------------------------------------------------
  // Typematic FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    code_d   = code_q;
    push     = 1'b0;
    push_rpt = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (key_on && !key_err) begin
          push    = 1'b1;
          timer_d = '0;
          code_d  = kb_io.ascii;
          state_d = StDelay;
        end
      end
      StDelay: begin
        if (key_err || !key_on) begin
          timer_d = '0;
          state_d = StIdle;
        end else if (key_new) begin
          // Rolling onto a different key restarts the initial delay.
          push    = 1'b1;
          timer_d = '0;
          code_d  = kb_io.ascii;
        end else if (timer_q == DelayLast) begin
          push     = 1'b1;
          push_rpt = 1'b1;
          timer_d  = '0;
          state_d  = StRepeat;
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end
      StRepeat: begin
        if (key_err || !key_on) begin
          timer_d = '0;
          state_d = StIdle;
        end else if (key_new) begin
          push    = 1'b1;
          timer_d = '0;
          code_d  = kb_io.ascii;
          state_d = StDelay;
        end else if (timer_q == RateLast) begin
          push     = 1'b1;
          push_rpt = 1'b1;
          timer_d  = '0;
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end
      default: begin
        timer_d = '0;
        state_d = StIdle;
      end
    endcase
  end

  // Repeat entries reuse the latched code but take the flags of the push cycle.
  assign push_entry = {push_rpt, kb_io.key_flags[3:0], push_rpt ? code_q : kb_io.ascii};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      timer_q <= '0;
      code_q  <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      code_q  <= code_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------------
  logic [12:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;

  logic full, empty, do_push, do_pop, drop;

  assign full    = (count_q == CntFull);
  assign empty   = (count_q == '0);
  assign do_pop  = kb_io.pop && !empty;
  // A pop in the same cycle frees the slot, so a push into a full queue still lands.
  assign do_push = push && (!full || do_pop);
  assign drop    = push && full && !do_pop;

  always_comb begin
    wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    // A dropped push wins over a coincident clear.
    if (drop) begin
      ovf_d = 1'b1;
    end else if (kb_io.clr_ovf) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage is never observed while empty, so it carries no reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_entry;
    end
  end

  // ---------------------------------------------------------------------------
  // Status/data word
  // ---------------------------------------------------------------------------
  logic [12:0] head;
  logic [4:0]  occ;

  assign head = empty ? 13'h0000 : mem_q[rd_ptr_q];
  // Occupancy field is 5 bits wide; at DEPTH=32 a full queue reads 0 here and bit 31 tells it apart.
  assign occ  = 5'(count_q);

  assign kb_io.q_data = {~empty, 6'b0, ovf_q, 3'b0, occ, 3'b0, head};

endmodule

// File: tb/tb_kb_event_queue.sv
// Bench for kb_event_queue at DEPTH=4, REPEAT_DELAY=20, REPEAT_RATE=5.
module tb_kb_event_queue;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  kb_event_queue_if bus ();

  kb_event_queue #(
    .DEPTH       (4),
    .REPEAT_DELAY(20),
    .REPEAT_RATE (5)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .kb_io(bus)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  logic [12:0] sb[$];

  typedef struct {
    logic [7:0]  ascii;
    logic [4:0]  flags;
    int          hold;
    int          nrep;
    logic [31:0] exp_q;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    bus.ascii     = 8'h00;
    bus.key_flags = 5'h00;
    bus.pop       = 1'b0;
    bus.clr_ovf   = 1'b0;
    sb.delete();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
  endtask

  task automatic release_key();
    bus.ascii     = 8'h00;
    bus.key_flags = 5'h00;
    tick(1);
  endtask

  // Compare the head against the scoreboard front, pop it, repeat until the scoreboard is empty.
  task automatic drain(input string name, input logic exp_ovf);
    logic [12:0] e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check({name, " head"}, {18'b0, bus.q_data[31], bus.q_data[12:0]}, {18'b0, 1'b1, e});
      bus.pop = 1'b1;
      tick(1);
      bus.pop = 1'b0;
    end
    check({name, " empty"}, bus.q_data, {7'b0, exp_ovf, 24'b0});
  endtask

  initial begin
    // ascii, flags, hold cycles, repeat entries expected, q_data after release
    vecs[0] = '{8'h61, 5'b00000, 3,  0, 32'h8001_0061};
    vecs[1] = '{8'h41, 5'b00001, 5,  0, 32'h8001_0141};
    vecs[2] = '{8'h0D, 5'b01000, 1,  0, 32'h8001_080D};
    vecs[3] = '{8'h63, 5'b00110, 20, 0, 32'h8001_0663};
    vecs[4] = '{8'h63, 5'b00110, 21, 1, 32'h8002_0663};
    vecs[5] = '{8'h30, 5'b10000, 5,  0, 32'h0000_0000};

    bus.ascii     = 8'h00;
    bus.key_flags = 5'h00;
    bus.pop       = 1'b0;
    bus.clr_ovf   = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("reset q_data", bus.q_data, 32'h0);
    tick(2);
    rst_n = 1'b1;

    // Single presses of various lengths and flags.
    for (int i = 0; i < 6; i++) begin
      bus.ascii     = vecs[i].ascii;
      bus.key_flags = vecs[i].flags;
      tick(vecs[i].hold);
      bus.ascii     = 8'h00;
      bus.key_flags = 5'h00;
      tick(2);
      check($sformatf("vec%0d q_data", i), bus.q_data, vecs[i].exp_q);
      if (!vecs[i].flags[4]) begin
        sb.push_back({1'b0, vecs[i].flags[3:0], vecs[i].ascii});
        for (int r = 0; r < vecs[i].nrep; r++) sb.push_back({1'b1, vecs[i].flags[3:0], vecs[i].ascii});
      end
      drain($sformatf("vec%0d", i), 1'b0);
    end

    // Long hold: entries at +1, +21, +26, +31, +36; the fifth overflows.
    do_reset();
    bus.ascii     = 8'h41;
    bus.key_flags = 5'b00001;
    for (int k = 1; k <= 40; k++) begin
      int   c;
      logic o;
      tick(1);
      c = int'(k >= 1) + int'(k >= 21) + int'(k >= 26) + int'(k >= 31) + int'(k >= 36);
      if (c > 4) c = 4;
      o = (k >= 36);
      check($sformatf("hold t%0d", k), bus.q_data,
            {1'b1, 6'b0, o, 3'b0, 5'(c), 3'b0, 13'h0141});
    end
    release_key();
    sb.push_back(13'h0141);
    for (int r = 0; r < 3; r++) sb.push_back(13'h1141);
    drain("hold", 1'b1);
    bus.clr_ovf = 1'b1;
    tick(1);
    bus.clr_ovf = 1'b0;
    check("hold ovf clear", bus.q_data, 32'h0);

    // Key change mid-delay restarts the repeat timer.
    do_reset();
    bus.ascii = 8'h61;
    tick(10);
    bus.ascii = 8'h62;
    tick(20);
    check("change no early repeat", bus.q_data, 32'h8002_0061);
    tick(1);
    check("change repeat", bus.q_data, 32'h8003_0061);
    release_key();
    sb.push_back(13'h0061);
    sb.push_back(13'h0062);
    sb.push_back(13'h1062);
    drain("change", 1'b0);

    // Full queue, repeat push coincides with pop.
    do_reset();
    bus.ascii     = 8'h41;
    bus.key_flags = 5'b00001;
    tick(35);
    check("full before", bus.q_data, 32'h8004_0141);
    sb.push_back(13'h0141);
    for (int r = 0; r < 3; r++) sb.push_back(13'h1141);
    void'(sb.pop_front());
    sb.push_back(13'h1141);
    bus.pop = 1'b1;
    tick(1);
    bus.pop = 1'b0;
    check("full push+pop", bus.q_data, 32'h8004_1141);
    release_key();
    drain("full", 1'b0);

    // Asynchronous reset while repeating.
    do_reset();
    bus.ascii = 8'h7A;
    tick(23);
    check("rst before", bus.q_data, 32'h8002_007A);
    rst_n = 1'b0;
    #2;
    check("rst async", bus.q_data, 32'h0);
    rst_n = 1'b1;
    #2;
    tick(1);
    check("rst repress", bus.q_data, 32'h8001_007A);
    release_key();
    sb.push_back(13'h007A);
    drain("rst", 1'b0);

    // Pop on empty, then push+pop while empty.
    do_reset();
    bus.pop = 1'b1;
    tick(1);
    check("pop empty", bus.q_data, 32'h0);
    bus.ascii = 8'h55;
    tick(1);
    bus.pop = 1'b0;
    check("empty push+pop", bus.q_data, 32'h8001_0055);
    release_key();
    sb.push_back(13'h0055);
    drain("emptypp", 1'b0);

    // clr_ovf colliding with a dropped push keeps overflow set.
    do_reset();
    bus.ascii     = 8'h41;
    bus.key_flags = 5'b00001;
    tick(35);
    bus.clr_ovf = 1'b1;
    tick(1);
    bus.clr_ovf   = 1'b0;
    check("clr vs drop", bus.q_data, 32'h8104_0141);
    bus.ascii     = 8'h00;
    bus.key_flags = 5'h00;
    bus.clr_ovf   = 1'b1;
    tick(1);
    bus.clr_ovf = 1'b0;
    check("clr alone", bus.q_data, 32'h8004_0141);
    sb.push_back(13'h0141);
    for (int r = 0; r < 3; r++) sb.push_back(13'h1141);
    drain("clr", 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
